// File: rtl/delay_line_prog.sv
// delay_line_prog: programmable circular-buffer delay line (0..DEPTH accepted samples).
// Optional feature macro: DLY_INVERT_EN adds the inv input, which XORs the delivered sample.
module delay_line_prog #(
    parameter int unsigned WIDTH       = 8,
    parameter int unsigned DEPTH       = 16,
    parameter int unsigned RESET_DELAY = 4
) (
    input  logic                     clk,
    input  logic                     rst,
`ifdef DLY_INVERT_EN
    input  logic                     inv,
`endif
    input  logic                     in_valid,
    input  logic [WIDTH-1:0]         in_data,
    input  logic                     cfg_load,
    input  logic [$clog2(DEPTH):0]   cfg_delay,
    output logic                     out_valid,
    output logic [WIDTH-1:0]         out_data,
    output logic [$clog2(DEPTH):0]   delay,
    output logic                     primed
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned DW = AW + 1;
    localparam logic [DW-1:0] DEPTH_W = DW'(DEPTH);
    localparam logic [DW-1:0] RST_DLY = DW'(RESET_DELAY);

    typedef enum logic {
        PRIME = 1'b0,
        RUN   = 1'b1
    } state_e;

    state_e            state_q, state_d;
    logic [WIDTH-1:0]  mem_q [DEPTH];
    logic [AW-1:0]     wptr_q, wptr_d;
    logic [DW-1:0]     fill_q, fill_d;
    logic [DW-1:0]     delay_q, delay_d;
    logic              out_valid_q, out_valid_d;
    logic [WIDTH-1:0]  out_data_q, out_data_d;

    logic              accept_c;
    logic              wr_en_c;
    logic [DW-1:0]     load_delay_c;
    logic [DW-1:0]     fill_inc_c;
    logic [AW-1:0]     rd_idx_c;
    logic [WIDTH-1:0]  dly_sample_c;
    logic [WIDTH-1:0]  inv_mask_c;

    // Shared decode: accept qualification, clamped load value, read index and delayed sample
    always_comb begin
        accept_c     = in_valid & ~cfg_load;
        load_delay_c = (cfg_delay > DEPTH_W) ? DEPTH_W : cfg_delay;
        fill_inc_c   = fill_q + DW'(1);
        // delay == DEPTH aliases to wptr itself, i.e. the oldest entry about to be overwritten
        rd_idx_c     = wptr_q - delay_q[AW-1:0];
        dly_sample_c = (delay_q == '0) ? in_data : mem_q[rd_idx_c];
`ifdef DLY_INVERT_EN
        inv_mask_c   = {WIDTH{inv}};
`else
        inv_mask_c   = '0;
`endif
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= (RST_DLY == '0) ? RUN : PRIME;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state: re-prime on load, enter RUN when the buffer holds a full delay
    always_comb begin
        state_d = state_q;
        if (cfg_load) begin
            state_d = (load_delay_c == '0) ? RUN : PRIME;
        end else if (accept_c && (state_q == PRIME) && (fill_inc_c == delay_q)) begin
            state_d = RUN;
        end
    end

    // FSM output decode
    always_comb begin
        primed = (state_q == RUN);
    end

    // Datapath next values: pointer, fill, delay and the registered output sample
    always_comb begin
        wptr_d      = wptr_q;
        fill_d      = fill_q;
        delay_d     = delay_q;
        out_valid_d = 1'b0;
        out_data_d  = out_data_q;
        wr_en_c     = 1'b0;
        if (cfg_load) begin
            delay_d = load_delay_c;
            fill_d  = '0;
        end else if (accept_c) begin
            wr_en_c = 1'b1;
            wptr_d  = wptr_q + AW'(1);
            if (fill_q == delay_q) begin
                out_valid_d = 1'b1;
                out_data_d  = dly_sample_c ^ inv_mask_c;
            end else begin
                fill_d = fill_inc_c;
            end
        end
    end

    // Datapath registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            wptr_q      <= '0;
            fill_q      <= '0;
            delay_q     <= RST_DLY;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
        end else begin
            wptr_q      <= wptr_d;
            fill_q      <= fill_d;
            delay_q     <= delay_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
        end
    end

    // Sample buffer; contents are never observable before being rewritten, so no reset
    always_ff @(posedge clk) begin
        if (wr_en_c && !rst) begin
            mem_q[wptr_q] <= in_data;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign delay     = delay_q;

endmodule

// File: tb/tb_delay_line_prog.sv
// Self-checking bench for delay_line_prog (default parameters WIDTH=8, DEPTH=16, RESET_DELAY=4).
module tb_delay_line_prog;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic [7:0] in_data;
    logic       cfg_load;
    logic [4:0] cfg_delay;
    logic       out_valid;
    logic [7:0] out_data;
    logic [4:0] delay;
    logic       primed;
`ifdef DLY_INVERT_EN
    logic       inv = 1'b0;
`endif

    typedef struct {
        logic       v;
        logic [7:0] d;
        logic [4:0] dl;
        logic       p;
    } exp_t;

    exp_t       sb[$];
    logic [7:0] hist[$];
    int         m_delay;
    logic [7:0] last_data;
    int         errors = 0;
    int         checks = 0;

    delay_line_prog dut (
        .clk       (clk),
        .rst       (rst),
`ifdef DLY_INVERT_EN
        .inv       (inv),
`endif
        .in_valid  (in_valid),
        .in_data   (in_data),
        .cfg_load  (cfg_load),
        .cfg_delay (cfg_delay),
        .out_valid (out_valid),
        .out_data  (out_data),
        .delay     (delay),
        .primed    (primed)
    );

    always #5 clk = ~clk;

    // Drive one cycle, predict the result into the scoreboard, sample #1 after the edge
    task automatic drive(input logic r, input logic v, input logic [7:0] d,
                         input logic ld, input logic [4:0] cfg);
        exp_t e;
        rst = r; in_valid = v; in_data = d; cfg_load = ld; cfg_delay = cfg;
        e.v = 1'b0;
        if (r) begin
            m_delay = 4; hist.delete(); last_data = 8'h00;
        end else if (ld) begin
            m_delay = (int'(cfg) > 16) ? 16 : int'(cfg);
            hist.delete();
        end else if (v) begin
            if (hist.size() >= m_delay) begin
                logic [7:0] val;
                val = (m_delay == 0) ? d : hist[hist.size() - m_delay];
`ifdef DLY_INVERT_EN
                if (inv) val = ~val;
`endif
                e.v = 1'b1;
                last_data = val;
            end
            hist.push_back(d);
            if (hist.size() > 40) void'(hist.pop_front());
        end
        e.d  = last_data;
        e.dl = 5'(m_delay);
        e.p  = (hist.size() >= m_delay);
        sb.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        exp_t e;
        for (int i = 0; i < 2; i++) begin
            drive(1'b1, 1'b1, 8'hFF, 1'b0, 5'd0);
            e = sb.pop_front();
            checks += 4;
            if (out_valid !== e.v) begin errors++; $display("FAIL reset[%0d] out_valid got %0b exp %0b", i, out_valid, e.v); end
            if (out_data !== e.d) begin errors++; $display("FAIL reset[%0d] out_data got %h exp %h", i, out_data, e.d); end
            if (delay !== e.dl) begin errors++; $display("FAIL reset[%0d] delay got %0d exp %0d", i, delay, e.dl); end
            if (primed !== e.p) begin errors++; $display("FAIL reset[%0d] primed got %0b exp %0b", i, primed, e.p); end
        end
    endtask

    task automatic test_prime_stream();
        exp_t e;
        for (int i = 1; i <= 12; i++) begin
            drive(1'b0, 1'b1, 8'(i), 1'b0, 5'd0);
            e = sb.pop_front();
            checks += 4;
            if (out_valid !== e.v) begin errors++; $display("FAIL prime[%0d] out_valid got %0b exp %0b", i, out_valid, e.v); end
            if (out_data !== e.d) begin errors++; $display("FAIL prime[%0d] out_data got %h exp %h", i, out_data, e.d); end
            if (delay !== e.dl) begin errors++; $display("FAIL prime[%0d] delay got %0d exp %0d", i, delay, e.dl); end
            if (primed !== e.p) begin errors++; $display("FAIL prime[%0d] primed got %0b exp %0b", i, primed, e.p); end
        end
    endtask

    task automatic test_delay0();
        exp_t e;
        logic [7:0] vals [4];
        vals[0] = 8'h00; vals[1] = 8'hA5; vals[2] = 8'h3C; vals[3] = 8'h0F;
        for (int i = 0; i < 4; i++) begin
            if (i == 0) drive(1'b0, 1'b1, 8'h99, 1'b1, 5'd0);
            else begin
`ifdef DLY_INVERT_EN
                inv = (i == 3);
`endif
                drive(1'b0, 1'b1, vals[i], 1'b0, 5'd0);
            end
            e = sb.pop_front();
            checks += 4;
            if (out_valid !== e.v) begin errors++; $display("FAIL delay0[%0d] out_valid got %0b exp %0b", i, out_valid, e.v); end
            if (out_data !== e.d) begin errors++; $display("FAIL delay0[%0d] out_data got %h exp %h", i, out_data, e.d); end
            if (delay !== e.dl) begin errors++; $display("FAIL delay0[%0d] delay got %0d exp %0d", i, delay, e.dl); end
            if (primed !== e.p) begin errors++; $display("FAIL delay0[%0d] primed got %0b exp %0b", i, primed, e.p); end
        end
`ifdef DLY_INVERT_EN
        inv = 1'b0;
`endif
    endtask

    // Full-depth delay across several pointer wraps; cfg is 16 or a clamped larger value
    task automatic test_depth(input logic [4:0] cfg, input logic [7:0] base);
        exp_t e;
        for (int i = -1; i <= 40; i++) begin
            if (i < 0) drive(1'b0, 1'b0, 8'h00, 1'b1, cfg);
            else       drive(1'b0, 1'b1, base + 8'(i), 1'b0, 5'd0);
            e = sb.pop_front();
            checks += 4;
            if (out_valid !== e.v) begin errors++; $display("FAIL depth%0d[%0d] out_valid got %0b exp %0b", cfg, i, out_valid, e.v); end
            if (out_data !== e.d) begin errors++; $display("FAIL depth%0d[%0d] out_data got %h exp %h", cfg, i, out_data, e.d); end
            if (delay !== e.dl) begin errors++; $display("FAIL depth%0d[%0d] delay got %0d exp %0d", cfg, i, delay, e.dl); end
            if (primed !== e.p) begin errors++; $display("FAIL depth%0d[%0d] primed got %0b exp %0b", cfg, i, primed, e.p); end
        end
    endtask

    task automatic test_gaps();
        exp_t e;
        logic [11:0] pat;
        pat = 12'b1011_1001_1011;
        for (int i = -1; i < 12; i++) begin
            if (i < 0) drive(1'b0, 1'b0, 8'h00, 1'b1, 5'd2);
            else       drive(1'b0, pat[11-i], 8'h40 + 8'(i), 1'b0, 5'd0);
            e = sb.pop_front();
            checks += 4;
            if (out_valid !== e.v) begin errors++; $display("FAIL gaps[%0d] out_valid got %0b exp %0b", i, out_valid, e.v); end
            if (out_data !== e.d) begin errors++; $display("FAIL gaps[%0d] out_data got %h exp %h", i, out_data, e.d); end
            if (delay !== e.dl) begin errors++; $display("FAIL gaps[%0d] delay got %0d exp %0d", i, delay, e.dl); end
            if (primed !== e.p) begin errors++; $display("FAIL gaps[%0d] primed got %0b exp %0b", i, primed, e.p); end
        end
    endtask

    // Load of 3 with in_valid high mid-stream: that sample is dropped and priming restarts
    task automatic test_midload();
        exp_t e;
        for (int i = 0; i < 12; i++) begin
            if (i == 5) drive(1'b0, 1'b1, 8'h77, 1'b1, 5'd3);
            else        drive(1'b0, 1'b1, 8'h60 + 8'(i), 1'b0, 5'd0);
            e = sb.pop_front();
            checks += 4;
            if (out_valid !== e.v) begin errors++; $display("FAIL midload[%0d] out_valid got %0b exp %0b", i, out_valid, e.v); end
            if (out_data !== e.d) begin errors++; $display("FAIL midload[%0d] out_data got %h exp %h", i, out_data, e.d); end
            if (delay !== e.dl) begin errors++; $display("FAIL midload[%0d] delay got %0d exp %0d", i, delay, e.dl); end
            if (primed !== e.p) begin errors++; $display("FAIL midload[%0d] primed got %0b exp %0b", i, primed, e.p); end
        end
    endtask

    task automatic test_mid_reset();
        exp_t e;
        for (int i = 0; i < 14; i++) begin
            if (i == 5) drive(1'b1, 1'b1, 8'hEE, 1'b0, 5'd0);
            else        drive(1'b0, 1'b1, 8'h80 + 8'(i), 1'b0, 5'd0);
            e = sb.pop_front();
            checks += 4;
            if (out_valid !== e.v) begin errors++; $display("FAIL midrst[%0d] out_valid got %0b exp %0b", i, out_valid, e.v); end
            if (out_data !== e.d) begin errors++; $display("FAIL midrst[%0d] out_data got %h exp %h", i, out_data, e.d); end
            if (delay !== e.dl) begin errors++; $display("FAIL midrst[%0d] delay got %0d exp %0d", i, delay, e.dl); end
            if (primed !== e.p) begin errors++; $display("FAIL midrst[%0d] primed got %0b exp %0b", i, primed, e.p); end
        end
    endtask

    // Random traffic with idle gaps and occasional reloads, including clamped values
    task automatic test_back_to_back();
        exp_t e;
        for (int i = 0; i < 300; i++) begin
            logic v, ld;
            v  = ($urandom_range(3) != 0);
            ld = ($urandom_range(29) == 0);
            drive(1'b0, v, 8'($urandom), ld, 5'($urandom_range(31)));
            e = sb.pop_front();
            checks += 4;
            if (out_valid !== e.v) begin errors++; $display("FAIL rand[%0d] out_valid got %0b exp %0b", i, out_valid, e.v); end
            if (out_data !== e.d) begin errors++; $display("FAIL rand[%0d] out_data got %h exp %h", i, out_data, e.d); end
            if (delay !== e.dl) begin errors++; $display("FAIL rand[%0d] delay got %0d exp %0d", i, delay, e.dl); end
            if (primed !== e.p) begin errors++; $display("FAIL rand[%0d] primed got %0b exp %0b", i, primed, e.p); end
        end
    endtask

    initial begin
        m_delay   = 4;
        last_data = 8'h00;
        rst = 1'b1; in_valid = 1'b0; in_data = 8'h00; cfg_load = 1'b0; cfg_delay = 5'd0;
        test_reset();
        test_prime_stream();
        test_delay0();
        test_depth(5'd16, 8'h00);
        test_depth(5'd31, 8'hC0);
        test_gaps();
        test_midload();
        test_mid_reset();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/delay_line_prog.md
Name: delay_line_prog

Overview:
- Parametrised, programmable digital delay line.
- Successor to the fixed combinational inverter path on the delay-line tile.
- Delays a WIDTH-bit sample stream by a run-time-selectable number of accepted samples (0..DEPTH), using a circular buffer.
- Tracks priming so that only fully delayed samples are presented. Sits between the tile's input pins and output pins, in the clk domain.

Parameters:
- WIDTH, 8, sample width in bits (>=1).
- DEPTH, 16, maximum delay in samples; power of two, >=2. AW = $clog2(DEPTH).
- RESET_DELAY, 4, delay loaded at reset (0..DEPTH).

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous reset, active-high.
- in_valid  in  1  sample present on in_data this cycle.
- in_data  in  WIDTH  input sample.
- cfg_load  in  1  load cfg_delay this cycle.
- cfg_delay  in  AW+1  requested delay in samples.
- out_valid  out  1  out_data holds a fully delayed sample (registered).
- out_data  out  WIDTH  delayed sample (registered).
- delay  out  AW+1  currently active delay.
- primed  out  1  1 = state RUN, 0 = state PRIME.
- inv  in  1  output invert; present only with DLY_INVERT_EN.

Behaviour:
- Reset (rst=1 at a clk edge):
  - delay = RESET_DELAY; write pointer = 0; fill = 0.
  - out_valid = 0; out_data = 0; state = PRIME, or RUN if RESET_DELAY = 0.
  - Buffer contents are not cleared; they are never observable before being rewritten.
  - Reset mid-stream discards all in-flight samples.
- Accept: a sample is accepted on any cycle with in_valid=1 and cfg_load=0.
- On each accepted sample:
  - Write in_data into mem[wptr]; wptr increments mod DEPTH.
  - Read mem[(wptr - delay) mod DEPTH] before the write, so delay = DEPTH returns the old entry being overwritten.
  - fill increments, saturating at delay.
- Output, 1-cycle latency:
  - If the sample is accepted with fill == delay (before the increment), then next cycle out_valid=1 and out_data = the sample accepted delay samples earlier.
  - delay = 0 bypasses the buffer: out_data = in_data of the same beat.
  - Otherwise next cycle out_valid=0 and out_data holds its previous value.
  - out_valid is a one-cycle pulse per delivered sample; there is no backpressure.
- States:
  - PRIME: fill < delay. Moves to RUN on the accepted sample that makes fill == delay. That sample's beat produces no output; the next accepted sample is the first delivered.
  - RUN: every accepted sample produces exactly one output.
- cfg_load=1:
  - delay = min(cfg_delay, DEPTH); values above DEPTH clamp to DEPTH.
  - fill = 0; wptr is unchanged.
  - State = PRIME, or RUN if the new delay is 0.
  - out_valid = 0 next cycle.
  - An in_valid asserted in the same cycle is dropped: not written, no output.
  - Loading the same value as the current delay still re-primes.
- Idle cycles (in_valid=0) advance nothing; the delay is measured in accepted samples, not clock cycles.
- fill width is AW+1; it never exceeds DEPTH.
- Pointer wrap: wptr is AW bits and wraps naturally; read-index subtraction is mod DEPTH.

Optional Feature:
- Macro: DLY_INVERT_EN.
- Defined:
  - Port inv exists.
  - Registered out_data = delayed sample XOR {WIDTH{inv}}, sampling inv on the same cycle the sample is accepted. This preserves the legacy inverting behaviour when delay=0 and inv=1.
  - Reset value of out_data remains 0.
- Undefined:
  - No inv port.
  - out_data is the delayed sample unmodified.

Test Plan:
- Reset, RESET_DELAY=4; stream 1,2,3,... with in_valid=1 every cycle -> no out_valid for samples 1..4; sample 5's beat outputs 1, then 2,3,... one cycle after each accept; primed rises after sample 4.
- cfg_delay=0 loaded, stream 0xA5,0x3C -> out_valid the next cycle each, out_data 0xA5, 0x3C; primed=1 immediately after load.
- cfg_delay=DEPTH (16), stream 0..40 -> first output on accept of sample 16 equals 0; outputs track input minus 16 across wptr wrap.
- cfg_delay=31 (> DEPTH) -> delay reads 16; behaviour identical to the previous case.
- In RUN with delay=2, apply gaps (in_valid toggling 1,0,0,1,1) -> outputs only after accepts, values still 2 samples back.
- Mid-stream cfg_load to 3 with in_valid=1 the same cycle -> that sample is dropped, out_valid=0 next cycle, primed=0; the next 3 accepts produce no output, the 4th outputs the first post-load sample.
- Mid-stream rst -> out_valid=0, out_data=0 next cycle; re-priming to RESET_DELAY is required.
- With DLY_INVERT_EN, delay=0, inv=1, in 0x0F -> out_data 0xF0.
